nonce_dispatcher: RTL

Work scheduler sitting between the AXI-facing job registers and an array of SHA-256 hashing cores in the snickerbits top. It accepts a job (start nonce and nonce count), hands nonces one per cycle to whichever cores are ready in round-robin order, and funnels core hit reports through a round-robin arbiter onto a single valid/ready result port. Completion and abort are sequenced here, so the cores hold no job-level state.

---
 rtl/sha256_pkg.sv | 15 +
 rtl/rr_pick.sv | 30 +++
 rtl/nonce_dispatcher.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared types and defaults for the snickerbits hashing-core scheduler.
package sha256_pkg;

    localparam int unsigned DEFAULT_N_CORES = 4;
    localparam int unsigned DEFAULT_NONCE_W = 32;

    typedef logic [DEFAULT_NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set finder: lowest set request at or above ptr, wrapping to bit 0.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int unsigned j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[IDX_W'(j)]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/nonce_dispatcher.sv
// Job scheduler: hands nonces to ready cores round-robin and merges core hits onto one port.
module nonce_dispatcher
    import sha256_pkg::*;
#(
    parameter int unsigned N_CORES = DEFAULT_N_CORES,
    parameter int unsigned NONCE_W = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                         clk_axi,
    input  logic                         rst,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [NONCE_W-1:0]           job_start,
    input  logic [NONCE_W-1:0]           job_count,
    input  logic                         abort,
    input  logic [N_CORES-1:0]           core_ready,
    output logic [N_CORES-1:0]           core_issue,
    output logic [NONCE_W-1:0]           core_nonce,
    input  logic [N_CORES-1:0]           core_idle,
    input  logic [N_CORES-1:0]           core_hit_valid,
    output logic [N_CORES-1:0]           core_hit_ready,
    input  logic [N_CORES*NONCE_W-1:0]   core_hit_nonce,
    output logic                         hit_valid,
    input  logic                         hit_ready,
    output logic [NONCE_W-1:0]           hit_nonce,
    output logic [$clog2(N_CORES)-1:0]   hit_core,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             hit_total
);

    localparam int unsigned IDX_W = $clog2(N_CORES);

    sched_state_t       state;
    logic [NONCE_W-1:0] nxt;
    logic [NONCE_W-1:0] remaining;
    logic [IDX_W-1:0]   issue_ptr;
    logic [IDX_W-1:0]   hit_ptr;
    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   hit_idx;
    logic               issue_found;
    logic               hit_found;
    logic               issue_fire;
    logic               slot_free;
    logic               hit_grant;
    logic               hit_take;
    logic [NONCE_W-1:0] hit_nonce_arr [N_CORES];

    for (genvar g = 0; g < N_CORES; g++) begin : g_hit_slice
        assign hit_nonce_arr[g] = core_hit_nonce[g*NONCE_W +: NONCE_W];
    end

    rr_pick #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_issue_pick (
        .req   (core_ready),
        .ptr   (issue_ptr),
        .found (issue_found),
        .idx   (issue_idx)
    );

    rr_pick #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_hit_pick (
        .req   (core_hit_valid),
        .ptr   (hit_ptr),
        .found (hit_found),
        .idx   (hit_idx)
    );

    always_comb begin
        // Abort suppresses any issue in the same cycle.
        issue_fire = (state == ISSUE) && !abort && issue_found;
        core_issue = '0;
        if (issue_fire) begin
            core_issue[issue_idx] = 1'b1;
        end
        core_nonce = issue_fire ? nxt : '0;

        hit_take       = hit_valid && hit_ready;
        slot_free      = !hit_valid || hit_ready;
        hit_grant      = slot_free && hit_found;
        core_hit_ready = '0;
        if (hit_grant) begin
            core_hit_ready[hit_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            state     <= IDLE;
            nxt       <= '0;
            remaining <= '0;
            issue_ptr <= '0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (job_valid) begin
                        nxt       <= job_start;
                        remaining <= job_count;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (job_count == '0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        nxt       <= nxt + NONCE_W'(1);
                        remaining <= remaining - NONCE_W'(1);
                        issue_ptr <= (issue_idx == IDX_W'(N_CORES - 1)) ? '0
                                                                        : issue_idx + IDX_W'(1);
                    end
                    if (abort || (issue_fire && remaining == NONCE_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Quiescence is sampled one cycle ahead so done lands in the second DRAIN cycle.
                    if (done) begin
                        state     <= IDLE;
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (&core_idle && !hit_valid && !(|core_hit_valid)) begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_axi) begin
        if (rst) begin
            hit_valid <= 1'b0;
            hit_nonce <= '0;
            hit_core  <= '0;
            hit_ptr   <= '0;
            hit_total <= '0;
        end else begin
            if (hit_grant) begin
                hit_valid <= 1'b1;
                hit_nonce <= hit_nonce_arr[hit_idx];
                hit_core  <= hit_idx;
                hit_ptr   <= (hit_idx == IDX_W'(N_CORES - 1)) ? '0 : hit_idx + IDX_W'(1);
            end else if (hit_take) begin
                hit_valid <= 1'b0;
            end
            if (hit_take && !(&hit_total)) begin
                hit_total <= hit_total + CNT_W'(1);
            end
        end
    end

endmodule
